// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and lane helpers for the mem_access_ctrl block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  function automatic logic is_illegal(input mem_size_t size, input logic [1:0] lo);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return lo[0];
      WORD:    return |lo;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input mem_size_t size, input logic [1:0] lo);
    case (size)
      BYTE:    return 4'b0001 << lo;
      HALF:    return 4'b0011 << lo;
      WORD:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input mem_size_t size, input logic [31:0] data);
    case (size)
      BYTE:    return {4{data[7:0]}};
      HALF:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Core request/response and Avalon-MM signals of mem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  // master: the controller itself (Avalon master, request target)
  modport master (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    input  readdata, waitrequest,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    output address, read, write, byteenable, writedata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    output readdata, waitrequest,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    input  address, read, write, byteenable, writedata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Selects the addressed lane(s) of readdata and extends to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lo,
  input  mem_size_t   i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lo, 3'b000} +: 8];
    w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      BYTE:    o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      HALF:    o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Avalon-MM master front end; one fetch/load/store at a time.
//               Define MEM_TIMEOUT_EN to abort stalled transfers after
//               TIMEOUT_CYCLES waitrequest cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.master bus
);
  mem_state_t  r_state, w_state_nxt;
  logic        r_write, w_write_nxt;
  logic [1:0]  r_lo, w_lo_nxt;
  mem_size_t   r_size, w_size_nxt;
  logic        r_signed, w_signed_nxt;
  logic [31:0] r_address, w_address_nxt;
  logic [3:0]  r_be, w_be_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_read, w_read_nxt;
  logic        r_wr, w_wr_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_busy, w_busy_nxt;
  mem_size_t   w_req_size;
  logic [31:0] w_ext;
  logic        w_timeout;

  assign w_req_size = mem_size_t'(bus.req_size);

  load_extract u_load_extract (
    .i_rdata  (bus.readdata),
    .i_lo     (r_lo),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;

  // Held at zero outside BUS, so every bus transfer starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset || r_state != BUS) r_to_cnt <= '0;
    else if (bus.waitrequest)    r_to_cnt <= r_to_cnt + 1'b1;
  end
  assign w_timeout = (r_state == BUS) && bus.waitrequest &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_lo        <= 2'd0;
      r_size      <= BYTE;
      r_signed    <= 1'b0;
      r_address   <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_read      <= 1'b0;
      r_wr        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_write     <= w_write_nxt;
      r_lo        <= w_lo_nxt;
      r_size      <= w_size_nxt;
      r_signed    <= w_signed_nxt;
      r_address   <= w_address_nxt;
      r_be        <= w_be_nxt;
      r_wdata     <= w_wdata_nxt;
      r_read      <= w_read_nxt;
      r_wr        <= w_wr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Every output is a flop, so each transition computes the values the
  // outputs take in the state being entered.
  always_comb begin
    w_state_nxt     = r_state;
    w_write_nxt     = r_write;
    w_lo_nxt        = r_lo;
    w_size_nxt      = r_size;
    w_signed_nxt    = r_signed;
    w_address_nxt   = r_address;
    w_be_nxt        = r_be;
    w_wdata_nxt     = r_wdata;
    w_read_nxt      = r_read;
    w_wr_nxt        = r_wr;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_req_ready_nxt = r_req_ready;
    w_busy_nxt      = r_busy;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_write_nxt     = bus.req_write;
          w_lo_nxt        = bus.req_addr[1:0];
          w_size_nxt      = w_req_size;
          w_signed_nxt    = bus.req_signed;
          w_req_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          if (is_illegal(w_req_size, bus.req_addr[1:0])) begin
            w_state_nxt     = ERR;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
          end else begin
            w_state_nxt   = BUS;
            w_read_nxt    = ~bus.req_write;
            w_wr_nxt      = bus.req_write;
            w_address_nxt = {bus.req_addr[31:2], 2'b00};
            w_be_nxt      = lane_enables(w_req_size, bus.req_addr[1:0]);
            w_wdata_nxt   = lane_wdata(w_req_size, bus.req_wdata);
          end
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          w_state_nxt     = RESP;
          w_read_nxt      = 1'b0;
          w_wr_nxt        = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_write ? 32'd0 : w_ext;
        end else if (w_timeout) begin
          w_state_nxt     = ERR;
          w_read_nxt      = 1'b0;
          w_wr_nxt        = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_req_ready_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.busy       = r_busy;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.address    = r_address;
  assign bus.read       = r_read;
  assign bus.write      = r_wr;
  assign bus.byteenable = r_be;
  assign bus.writedata  = r_wdata;
endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Avalon-MM master front end for the multicycle MIPS core. It takes one fetch or data request at a time from the control FSM and drives the `read`/`write`, `byteenable` and `waitrequest` handshake. It returns lane-aligned, size-extended read data; fetch responses feed the instruction register's write-data input directly. Misaligned or illegal-size requests are rejected before any bus cycle.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, number of consecutive `waitrequest` cycles before a timeout. Used only with `MEM_TIMEOUT_EN`.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present this cycle
- req_write  in  1  1 = store, 0 = load/fetch
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  sign-extend load data (byte/half only)
- req_wdata  in  32  store data, right-justified
- req_ready  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies `rsp_valid`: misaligned, illegal size or timeout
- rsp_rdata  out  32  extended load data; 0 for stores and errors; held until the next `rsp_valid`
- busy  out  1  state is not IDLE
- address  out  32  word-aligned bus address (`req_addr & ~3`)
- read  out  1  Avalon read
- write  out  1  Avalon write
- byteenable  out  4  lane enables; lane 0 = bits 7:0
- writedata  out  32  lane-replicated store data
- readdata  in  32  Avalon read data
- waitrequest  in  1  Avalon stall

## Operation
- States: IDLE, BUS, RESP, ERR.
- **IDLE**
  - On accept, latch address, size, signed and write data.
  - Illegal request (size 3, half with `addr[0]` set, or word with `addr[1:0]` nonzero) -> ERR.
  - Otherwise -> BUS.
- **BUS**
  - `read` or `write` is held high, with address, byteenable and writedata stable.
  - When `waitrequest` is 0: capture `readdata` and go to RESP.
- **RESP**: `rsp_valid` = 1, `rsp_err` = 0 for one cycle, then -> IDLE.
- **ERR**: `rsp_valid` = 1, `rsp_err` = 1 for one cycle, then -> IDLE. No bus activity occurs.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load data:
  - Select the lane(s) given by `addr[1:0]`.
  - Zero- or sign-extend to 32 bits according to `req_signed`.
  - `req_signed` is ignored for words.
- All outputs are registered.
- Reset values: state IDLE, `read`/`write`/`rsp_valid`/`rsp_err` = 0, `address`/`writedata`/`rsp_rdata` = 0, `byteenable` = 0, `req_ready` = 1, `busy` = 0.

## Timing
- **Accept cycle N**: `read`/`write` is asserted from edge N+1.
- **Zero-wait transfer**: `waitrequest` = 0 at N+1 gives `rsp_valid` at N+2, which is 2 cycles of latency. Each wait cycle adds 1.
- **Read data capture**: data is sampled on the edge where `read && !waitrequest`. `read` drops on the same edge.
- **Invalid request**: `rsp_valid` is asserted at N+1.
- **Request spacing**: `req_ready` is 0 from N+1 until the edge after `rsp_valid`, so the minimum spacing between requests is 3 cycles.
- **Reset mid-transaction**: reset in BUS or RESP returns to IDLE on that edge. `read`/`write` drop immediately and no `rsp_valid` is issued.
- **`req_valid` while not ready**: ignored; no queueing.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter counts consecutive BUS cycles with `waitrequest` = 1.
  - On reaching TIMEOUT_CYCLES, drop `read`/`write` and go to ERR.
  - `rsp_rdata` is set to 0.
  - The counter clears on entry to BUS.
- `MEM_TIMEOUT_EN` undefined: no counter is built and BUS waits indefinitely.

## Structure
- `mem_ctrl_pkg` holds:
  - the `mem_size_t` enum (BYTE, HALF, WORD, ILLEGAL)
  - the `mem_state_t` enum (IDLE, BUS, RESP, ERR)
  - the lane/enable helper functions
- One sub-module, `load_extract`: takes `readdata`, `addr[1:0]`, size and signed, and produces the 32-bit extended result. It is purely combinational and instantiated before the capture register.

## Test plan
- **Word fetch, zero wait**: request at 0x0000_0010, `readdata` 0x2402_0005 -> `read` high for 1 cycle, address 0x10, `byteenable` 4'hF, `rsp_rdata` 0x2402_0005 at N+2.
- **Signed byte load with 3 wait cycles**: addr 0x103, `readdata` 0x80FF_0000 -> `byteenable` 4'h8, `read` high for 4 cycles, `rsp_rdata` 0xFFFF_FF80. Repeated unsigned -> 0x0000_0080.
- **Half store**: addr 0x202, wdata 0x1234_ABCD -> `write` 1, `byteenable` 4'hC, `writedata` 0xABCD_ABCD, address 0x200, then `rsp_valid` with `rsp_rdata` 0.
- **Illegal requests**: word at 0x301, then size 3 -> each gives `rsp_valid` and `rsp_err` at N+1, with `read`/`write` never asserted.
- **Reset in BUS**: reset with `waitrequest` held high -> next cycle state IDLE, `read` 0, `req_ready` 1, no `rsp_valid`.
- **Timeout (`MEM_TIMEOUT_EN`, TIMEOUT_CYCLES = 4)**: `waitrequest` stuck at 1 -> `read` drops after 4 cycles, then `rsp_valid` and `rsp_err` with `rsp_rdata` 0.
